// File: rtl/fifo_read_packer_if.sv
// Bundles the FIFO read handshake and the packed-beat stream of fifo_read_packer.
// The master modport is the packer's view; slave is the FIFO/downstream view.
interface fifo_read_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_COUNT = 4
);
    localparam int OUT_WIDTH = DATA_WIDTH * PACK_COUNT;

    logic                  fifo_empty;
    logic                  fifo_read_ready;
    logic                  fifo_read_valid;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  flush;
    logic [OUT_WIDTH-1:0]  out_data;
    logic [PACK_COUNT-1:0] out_keep;
    logic                  out_valid;
    logic                  out_ready;
    logic                  protocol_err;

    modport master (
        input  fifo_empty,
        output fifo_read_ready,
        input  fifo_read_valid,
        input  fifo_data,
        input  flush,
        output out_data,
        output out_keep,
        output out_valid,
        input  out_ready,
        output protocol_err
    );

    modport slave (
        output fifo_empty,
        input  fifo_read_ready,
        output fifo_read_valid,
        output fifo_data,
        output flush,
        input  out_data,
        input  out_keep,
        input  out_valid,
        output out_ready,
        input  protocol_err
    );
endinterface

// File: rtl/fifo_read_packer.sv
// Pops words from a synchronous FIFO (request now, data next cycle) and packs
// PACK_COUNT of them into one wide valid/ready beat; a flush emits a partial beat.
module fifo_read_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_COUNT = 4
) (
    input logic              clk,
    input logic              rst_n,
    fifo_read_packer_if.master bus
);
    localparam int OUT_WIDTH = DATA_WIDTH * PACK_COUNT;
    localparam int CNT_W     = $clog2(PACK_COUNT + 1);
    localparam logic [CNT_W-1:0] LANE_FULL = CNT_W'(PACK_COUNT);
    localparam logic [CNT_W:0]   SLOT_MAX  = (CNT_W + 1)'(PACK_COUNT);

    typedef enum logic {
        ST_FILL,
        ST_HOLD
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_lane_cnt;
    logic [CNT_W-1:0]      w_lane_cnt_next;
    logic [OUT_WIDTH-1:0]  r_data;
    logic [OUT_WIDTH-1:0]  w_data_next;
    logic [PACK_COUNT-1:0] r_keep;
    logic [PACK_COUNT-1:0] w_keep_next;
    logic                  r_req_pending;
    logic                  r_flush_pending;
    logic                  w_flush_pending_next;
    logic                  r_started;
    logic                  r_protocol_err;

    logic [CNT_W:0]        w_slots;
    logic                  w_pop;
    logic                  w_capture;
    logic                  w_stray;
    logic                  w_handshake;

    // Lanes already filled plus the one response still in flight.
    assign w_slots = {1'b0, r_lane_cnt} + {{CNT_W{1'b0}}, r_req_pending};

    // r_started keeps the pop request low through reset and the first cycle after it.
    assign w_pop = r_started && (r_state == ST_FILL) && !bus.fifo_empty
                   && !r_flush_pending && (w_slots < SLOT_MAX);

    assign w_capture   = bus.fifo_read_valid && r_req_pending;
    assign w_stray     = bus.fifo_read_valid && !r_req_pending;
    assign w_handshake = (r_state == ST_HOLD) && bus.out_ready;

    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        w_state_next         = r_state;
        w_lane_cnt_next      = r_lane_cnt;
        w_data_next          = r_data;
        w_keep_next          = r_keep;
        w_flush_pending_next = r_flush_pending | bus.flush;

        unique case (r_state)
            ST_FILL: begin
                if (w_capture) begin
                    for (int i = 0; i < PACK_COUNT; i++) begin
                        if (r_lane_cnt == CNT_W'(i)) begin
                            w_data_next[i*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data;
                            w_keep_next[i]                          = 1'b1;
                        end
                    end
                    w_lane_cnt_next = r_lane_cnt + CNT_W'(1);
                    if (w_lane_cnt_next == LANE_FULL) begin
                        w_state_next = ST_HOLD;
                    end
                end else if (r_flush_pending && !r_req_pending) begin
                    if (r_lane_cnt != '0) begin
                        w_state_next = ST_HOLD;
                    end else begin
                        // Nothing captured: drop the flush, but keep a fresh pulse.
                        w_flush_pending_next = bus.flush;
                    end
                end
            end

            ST_HOLD: begin
                if (w_handshake) begin
                    w_state_next    = ST_FILL;
                    w_lane_cnt_next = '0;
                    w_data_next     = '0;
                    w_keep_next     = '0;
                    // A partial beat can only have been caused by the pending flush.
                    if (!r_keep[PACK_COUNT-1]) begin
                        w_flush_pending_next = bus.flush;
                    end
                end
            end

            default: w_state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_FILL;
            r_lane_cnt      <= '0;
            // NOTE: the lane accumulator is reset because out_data must read zero
            // after reset and unused lanes must stay zero; a plain buffer would not be.
            r_data          <= '0;
            r_keep          <= '0;
            r_req_pending   <= 1'b0;
            r_flush_pending <= 1'b0;
            r_started       <= 1'b0;
            r_protocol_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state         <= w_state_next;
            r_lane_cnt      <= w_lane_cnt_next;
            r_data          <= w_data_next;
            r_keep          <= w_keep_next;
            r_req_pending   <= w_pop;
            r_flush_pending <= w_flush_pending_next;
            r_started       <= 1'b1;
            if (w_stray && r_started) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    assign bus.fifo_read_ready = w_pop;
    assign bus.out_data        = r_data;
    assign bus.out_keep        = r_keep;
    assign bus.out_valid       = (r_state == ST_HOLD);
    assign bus.protocol_err    = r_protocol_err;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer: a queue models the FIFO (data one cycle
// after a pop), a vector table covers full/partial beats, hand sequences cover corners.
module tb_fifo_read_packer;
    localparam int DW = 8;
    localparam int PC = 4;
    localparam int OW = DW * PC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fifo_read_packer_if #(.DATA_WIDTH(DW), .PACK_COUNT(PC)) bus ();

    fifo_read_packer #(.DATA_WIDTH(DW), .PACK_COUNT(PC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int            n_words;
        logic [OW-1:0] words;     // word k in bits [k*DW +: DW]
        int            flush_at;  // cycle of the flush pulse, -1 for none
        bit            exp_beat;
        logic [OW-1:0] exp_data;
        logic [PC-1:0] exp_keep;
    } vec_t;

    vec_t          vecs[7];
    logic [DW-1:0] fifo_q[$];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        bus.fifo_empty = 1'b0;
        #1;
    endtask

    // One clock: pop if requested, answer one cycle later, then let outputs settle.
    task automatic step();
        bit            pop;
        logic [DW-1:0] w;
        pop = bus.fifo_read_ready && !bus.fifo_empty;
        w   = '0;
        if (pop) w = fifo_q.pop_front();
        @(posedge clk);
        #1;
        bus.fifo_read_valid = pop;
        bus.fifo_data       = w;
        bus.fifo_empty      = (fifo_q.size() == 0);
        #1;
    endtask

    task automatic wait_beat(input string name, input int budget);
        int cyc;
        cyc = 0;
        while (!bus.out_valid && cyc < budget) begin
            step();
            cyc++;
        end
        check({name, "_beat_seen"}, OW'(bus.out_valid), OW'(1));
    endtask

    task automatic handshake(input string name);
        bus.out_ready = 1'b1;
        step();
        check({name, "_valid_after_hs"}, OW'(bus.out_valid), OW'(0));
        check({name, "_data_after_hs"}, bus.out_data, OW'(0));
        check({name, "_keep_after_hs"}, OW'(bus.out_keep), OW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   first_req;
        int   beat_c;
        int   pops;
        int   bad;
        int   reqs;
        logic [OW-1:0] held;

        vecs[0] = '{4, 32'h44332211, -1, 1'b1, 32'h44332211, 4'b1111};
        vecs[1] = '{4, 32'h44332211,  4, 1'b1, 32'h44332211, 4'b1111};
        vecs[2] = '{4, 32'hEFBEADDE, -1, 1'b1, 32'hEFBEADDE, 4'b1111};
        vecs[3] = '{2, 32'h0000BBAA,  4, 1'b1, 32'h0000BBAA, 4'b0011};
        vecs[4] = '{1, 32'h0000005A,  3, 1'b1, 32'h0000005A, 4'b0001};
        vecs[5] = '{3, 32'h00030201,  5, 1'b1, 32'h00030201, 4'b0111};
        vecs[6] = '{0, 32'h00000000,  1, 1'b0, 32'h00000000, 4'b0000};

        bus.fifo_empty      = 1'b1;
        bus.fifo_read_valid = 1'b0;
        bus.fifo_data       = '0;
        bus.flush           = 1'b0;
        bus.out_ready       = 1'b1;

        // Reset values, with the FIFO claiming data so a leaky request would show.
        #12;
        bus.fifo_empty = 1'b0;
        #1;
        check("rst_read_ready", OW'(bus.fifo_read_ready), OW'(0));
        check("rst_out_valid", OW'(bus.out_valid), OW'(0));
        check("rst_out_data", bus.out_data, OW'(0));
        check("rst_out_keep", OW'(bus.out_keep), OW'(0));
        check("rst_protocol_err", OW'(bus.protocol_err), OW'(0));
        bus.fifo_empty = 1'b1;

        // A stray response in the first cycle after release is dropped silently.
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.fifo_read_valid = 1'b1;
        bus.fifo_data       = 8'h5E;
        #1;
        step();
        step();
        check("first_cycle_stray_quiet", OW'(bus.protocol_err), OW'(0));
        check("first_cycle_stray_keep", OW'(bus.out_keep), OW'(0));

        for (int i = 0; i < 7; i++) begin
            v         = vecs[i];
            first_req = -1;
            beat_c    = -1;
            pops      = 0;
            for (int k = 0; k < v.n_words; k++) push(v.words[k*DW +: DW]);
            for (int c = 0; c < 16; c++) begin
                if (bus.out_valid) begin
                    beat_c = c;
                    break;
                end
                if (bus.fifo_read_ready) begin
                    pops++;
                    if (first_req < 0) first_req = c;
                end
                bus.flush = (c == v.flush_at);
                step();
                bus.flush = 1'b0;
            end
            check($sformatf("vec%0d_beat_seen", i), OW'(beat_c >= 0), OW'(v.exp_beat));
            check($sformatf("vec%0d_pops", i), OW'(pops), OW'(v.n_words));
            if (beat_c >= 0) begin
                check($sformatf("vec%0d_data", i), bus.out_data, v.exp_data);
                check($sformatf("vec%0d_keep", i), OW'(bus.out_keep), OW'(v.exp_keep));
                if (v.n_words == PC && v.flush_at < 0)
                    check($sformatf("vec%0d_latency", i), OW'(beat_c - first_req), OW'(PC + 1));
                handshake($sformatf("vec%0d", i));
            end
            repeat (3) step();
            check($sformatf("vec%0d_idle", i), OW'(bus.out_valid), OW'(0));
        end

        // Backpressure: the first beat holds and no pops happen while held.
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) push(DW'(k));
        wait_beat("bp1", 20);
        check("bp1_data", bus.out_data, 32'h04030201);
        check("bp1_keep", OW'(bus.out_keep), OW'(4'b1111));
        held = bus.out_data;
        bad  = 0;
        reqs = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.fifo_read_ready) reqs++;
            step();
            if (!bus.out_valid || bus.out_data !== held) bad++;
        end
        check("bp_hold_stable", OW'(bad), OW'(0));
        check("bp_no_requests", OW'(reqs), OW'(0));
        handshake("bp1");
        wait_beat("bp2", 12);
        check("bp2_data", bus.out_data, 32'h08070605);
        check("bp2_keep", OW'(bus.out_keep), OW'(4'b1111));
        handshake("bp2");
        repeat (2) step();

        // Flush raised in the cycle of a request: the in-flight word still lands.
        push(8'hAA);
        push(8'hBB);
        step();
        step();
        push(8'hCC);
        check("inflight_req_high", OW'(bus.fifo_read_ready), OW'(1));
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        wait_beat("inflight", 8);
        check("inflight_data", bus.out_data, 32'h00CCBBAA);
        check("inflight_keep", OW'(bus.out_keep), OW'(4'b0111));
        handshake("inflight");
        repeat (3) step();
        check("inflight_no_extra_beat", OW'(bus.out_valid), OW'(0));

        // Stray response with nothing requested: dropped and latched as an error.
        bus.fifo_read_valid = 1'b1;
        bus.fifo_data       = 8'h77;
        #1;
        step();
        check("stray_err_set", OW'(bus.protocol_err), OW'(1));
        check("stray_dropped", OW'(bus.out_keep), OW'(0));
        repeat (5) step();
        check("stray_err_sticky", OW'(bus.protocol_err), OW'(1));

        // Asynchronous reset after two captures, then a clean beat of new bytes.
        push(8'h91);
        push(8'h92);
        push(8'h93);
        push(8'h94);
        repeat (3) step();
        check("midfill_keep_before", OW'(bus.out_keep), OW'(4'b0011));
        #1;
        rst_n = 1'b0;
        fifo_q.delete();
        bus.fifo_read_valid = 1'b0;
        bus.fifo_data       = '0;
        bus.fifo_empty      = 1'b1;
        #1;
        check("midfill_keep_async", OW'(bus.out_keep), OW'(0));
        check("midfill_data_async", bus.out_data, OW'(0));
        check("midfill_err_cleared", OW'(bus.protocol_err), OW'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        step();
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        wait_beat("midfill", 12);
        check("midfill_data", bus.out_data, 32'hA4A3A2A1);
        check("midfill_keep", OW'(bus.out_keep), OW'(4'b1111));
        handshake("midfill");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_read_packer.md
# fifo_read_packer

Consumer for the read side of the team's synchronous FIFO. It pops `DATA_WIDTH`-bit words with the FIFO's request/response read handshake and packs `PACK_COUNT` consecutive words into one wide beat. It presents each beat on a downstream valid/ready interface and can flush a partially filled beat on request. It sits between a byte-oriented FIFO and a wider datapath, such as a bus master or memory writer.

## Interface
- `DATA_WIDTH`, 8: width of one FIFO word.
- `PACK_COUNT`, 4: words per output beat; must be ≥2.
- `OUT_WIDTH`, `DATA_WIDTH*PACK_COUNT`: output beat width; derived, do not override.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_read_ready`  out  1  pop request to the FIFO.
- `fifo_read_valid`  in  1  FIFO response: `fifo_data` valid this cycle.
- `fifo_data`  in  `DATA_WIDTH`  popped word.
- `flush`  in  1  single-cycle pulse: emit the current partial beat.
- `out_data`  out  `OUT_WIDTH`  packed beat; lane 0 (bits `[DATA_WIDTH-1:0]`) holds the oldest word.
- `out_keep`  out  `PACK_COUNT`  per-lane valid mask; always contiguous from lane 0.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  downstream accepts the beat.
- `protocol_err`  out  1  sticky: `fifo_read_valid` arrived with no request outstanding.

## Operation
- **FIFO read protocol.**
  - Raising `fifo_read_ready` in cycle N while `fifo_empty`=0 pops one word.
  - The FIFO answers with `fifo_read_valid`=1 and `fifo_data` in cycle N+1.
  - A request made while the FIFO is empty returns `fifo_read_valid`=0 in N+1; treat it as no data.
- **Internal state.** `lane_cnt` (0..`PACK_COUNT`), `req_pending` (request issued last cycle), `flush_pending`, and the lane accumulator.
- **FILL state.**
  - `fifo_read_ready` = !`fifo_empty` && !`flush_pending` && (`lane_cnt` + `req_pending` < `PACK_COUNT`).
  - The block never over-requests, so at most one request is outstanding per lane slot.
- **Capture.**
  - On `fifo_read_valid` && `req_pending`, write `fifo_data` into lane `lane_cnt`, set `out_keep[lane_cnt]`, and increment `lane_cnt`.
  - When `lane_cnt` reaches `PACK_COUNT`, go to HOLD.
- **Flush.**
  - A `flush` pulse sets `flush_pending`, which blocks new requests.
  - Once `req_pending`=0 and `lane_cnt`>0, go to HOLD with a partial `out_keep`.
  - If `lane_cnt`=0 and `req_pending`=0, the flush is discarded and `flush_pending` clears.
  - A `flush` that arrives during HOLD is held pending and applies after the handshake.
- **HOLD state.**
  - `out_valid`=1; `out_data`/`out_keep` are stable; no FIFO requests.
  - On `out_valid && out_ready`: clear lanes to 0, `out_keep`=0, `lane_cnt`=0, clear `flush_pending` if it was the cause, and return to FILL.
- **Unused lanes** of `out_data` are always 0.
- **Protocol error.** `fifo_read_valid`=1 with `req_pending`=0 discards the word and sets `protocol_err` until reset.
  - Exception: in the first cycle after `rst_n` deasserts, a stray response is dropped silently.

## Timing
- **Reset values.** `fifo_read_ready`=0, `out_valid`=0, `out_data`=0, `out_keep`=0, `protocol_err`=0; state FILL, all counters 0.
- **Reset mid-operation.** Partial lanes and in-flight requests are discarded.
- **Full-beat latency.** With a non-empty FIFO and requests in cycles 0..`PACK_COUNT`-1:
  - Responses arrive in cycles 1..`PACK_COUNT`.
  - `out_valid` rises at the start of cycle `PACK_COUNT`+1 (registered).
- **After a handshake** in cycle H, the first new request is cycle H+1.
  - Peak rate is one beat per `PACK_COUNT`+2 cycles.
- **Simultaneous events.**
  - `flush` in the same cycle as the final capture completes the full beat normally, then the flush is discarded (`lane_cnt`=0 after the handshake).
  - `flush` with a request in flight waits one cycle for the response.
- **FIFO emptying between request and response.** A `fifo_read_valid`=0 response clears `req_pending` without capturing.

## Test plan
- **Full beat.** Preload FIFO 0x11,0x22,0x33,0x44; `out_ready`=1 → `fifo_read_ready` high cycles 0-3; `out_valid` in cycle 5 with `out_data`=0x44332211, `out_keep`=4'b1111.
- **Backpressure.** Preload 8 bytes 0x01..0x08; `out_ready`=0 for 10 cycles.
  - First beat 0x04030201 holds stable.
  - No requests issue while holding.
  - After release, second beat is 0x08070605.
- **Partial flush.** Preload 0xAA,0xBB; pulse `flush` in cycle 4 → beat `out_data`=0x0000BBAA, `out_keep`=4'b0011.
  - A `flush` with nothing captured produces no beat.
- **Flush with request in flight.** Write 0xCC so it becomes visible while 0xAA,0xBB are captured; assert `flush` the same cycle `fifo_read_ready`=1 → 0xCC is captured, beat 0x00CCBBAA with keep 4'b0111.
- **Stray response.** Drive `fifo_read_valid`=1 with no request → word dropped, `protocol_err`=1, held until `rst_n` low.
- **Async reset mid-fill.** Reset after 2 captures; release; preload 4 new bytes → a clean full beat with the new bytes only.
